// File: rtl/tt_alu_pkg.sv
// Shared op codes, default widths and pad-control constants for the accumulator ALU.
package tt_alu_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_ACC_W = 8;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_ACC_ADD = 3'b010,
        OP_ACC_SUB = 3'b011,
        OP_CLR     = 3'b100
    } op_e;

    localparam int IN_VALID_BIT = 3;
    localparam int SAT_EN_BIT   = 4;

    // Only the three flag pads on uio[7:5] are driven.
    localparam logic [7:0] UIO_OE_MASK = 8'b1110_0000;

endpackage

// File: rtl/alu_sat_addsub.sv
// Combinational W-bit add/subtract with carry/borrow flag and optional saturation.
module alu_sat_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         sub_i,
    input  logic         sat_en_i,
    output logic [W-1:0] res_o,
    output logic         flag_o
);

    logic [W:0] raw;

    always_comb begin
        raw = sub_i ? ({1'b0, x_i} - {1'b0, y_i}) : ({1'b0, x_i} + {1'b0, y_i});
        flag_o = raw[W];
        // Saturate toward the bound that was crossed: floor on borrow, ceiling on carry.
        if (sat_en_i && flag_o) begin
            res_o = sub_i ? '0 : '1;
        end else begin
            res_o = raw[W-1:0];
        end
    end

endmodule

// File: rtl/tt_um_accum_alu.sv
// Two-stage accumulator ALU: stage 1 registers the request, stage 2 computes and
// updates result, accumulator and sticky overflow.
module tt_um_accum_alu
    import tt_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    input  logic       ena,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             sat_q, vld_q;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             out_vld_q, out_vld_d;

    logic [ACC_W-1:0] alu_x, alu_y, alu_res;
    logic             alu_sub, alu_flag, is_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            sat_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= uio_in[IN_VALID_BIT];
            if (uio_in[IN_VALID_BIT]) begin
                a_q   <= ui_in[WIDTH-1:0];
                b_q   <= ui_in[4+WIDTH-1:4];
                op_q  <= uio_in[2:0];
                sat_q <= uio_in[SAT_EN_BIT];
            end
        end
    end

    // One shared adder: plain ops combine A/B, accumulator ops combine acc/A.
    always_comb begin
        is_acc  = (op_q == OP_ACC_ADD) || (op_q == OP_ACC_SUB);
        alu_sub = (op_q == OP_SUB) || (op_q == OP_ACC_SUB);
        alu_x   = is_acc ? acc_q : ACC_W'(a_q);
        alu_y   = is_acc ? ACC_W'(a_q) : ACC_W'(b_q);
    end

    alu_sat_addsub #(.W(ACC_W)) u_addsub (
        .x_i      (alu_x),
        .y_i      (alu_y),
        .sub_i    (alu_sub),
        .sat_en_i (sat_q),
        .res_o    (alu_res),
        .flag_o   (alu_flag)
    );

    always_comb begin
        acc_d     = acc_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        out_vld_d = vld_q;
        if (vld_q) begin
            case (op_q)
                OP_ADD, OP_SUB: begin
                    result_d = alu_res;
                    ovf_d    = ovf_q | alu_flag;
                end
                OP_ACC_ADD, OP_ACC_SUB: begin
                    acc_d    = alu_res;
                    result_d = alu_res;
                    ovf_d    = ovf_q | alu_flag;
                end
                OP_CLR: begin
                    acc_d    = '0;
                    result_d = '0;
                    ovf_d    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign uo_out  = 8'(result_q);
    assign uio_out = {out_vld_q, ovf_q, (result_q == '0), 5'b0_0000};
    assign uio_oe  = UIO_OE_MASK;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:5], ui_in};

endmodule

// File: doc/tt_um_accum_alu.md
TT_UM_ACCUM_ALU -- requirements
Module: tt_um_accum_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width (legal 2..4).
REQ-002 SHALL have parameter: ACC_W, 8, accumulator/result width (legal WIDTH+1..8).
REQ-003 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: ui_in  in  8  [WIDTH-1:0] operand A, [4+WIDTH-1:4] operand B; other bits ignored.
REQ-006 SHALL have port: uio_in  in  8  [2:0] op, [3] in_valid, [4] sat_en; [7:5] ignored.
REQ-007 SHALL have port: uo_out  out  8  result register, zero-extended above ACC_W.
REQ-008 SHALL have port: uio_out  out  8  [7] out_valid, [6] ovf (sticky), [5] zero; [4:0] = 0.
REQ-009 SHALL have port: uio_oe  out  8  constant 8'b1110_0000.
REQ-010 SHALL have port: ena  in  1  ignored.

Function
REQ-011 Op codes SHALL be: 000 ADD, 001 SUB, 010 ACC_ADD, 011 ACC_SUB, 100 CLR, 101..111 NOP.
REQ-012 Stage 1 SHALL capture A, B, op, sat_en when in_valid=1; stage 2 SHALL compute and update result/acc/flags.
REQ-013 out_valid SHALL assert exactly 2 cycles after the edge sampling in_valid=1, for one cycle per accepted input.
REQ-014 Throughput SHALL be one operation per cycle; back-to-back in_valid SHALL be accepted with no bubbles.
REQ-015 in_valid=0 cycles SHALL leave result, acc, ovf unchanged and out_valid=0 two cycles later.
REQ-016 ADD: result = zext(A)+zext(B) in ACC_W bits; acc unchanged.
REQ-017 SUB: raw = zext(A)-zext(B) mod 2^ACC_W; borrow sets ovf; sat_en=1 with borrow gives result 0.
REQ-018 ACC_ADD: acc = acc+zext(A); carry-out sets ovf; sat_en=1 with carry gives acc = 2^ACC_W-1; result = new acc.
REQ-019 ACC_SUB: acc = acc-zext(A); borrow sets ovf; sat_en=1 with borrow gives acc 0; result = new acc.
REQ-020 Without sat_en, all ops SHALL wrap modulo 2^ACC_W.
REQ-021 CLR: acc=0, result=0, ovf=0; out_valid asserts as for any op.
REQ-022 NOP: result/acc/ovf unchanged; out_valid still asserts.
REQ-023 ovf SHALL stay set until CLR or reset; ovf set and CLR never coincide in one op.
REQ-024 zero SHALL equal (result==0), registered with result.
REQ-025 Dependent back-to-back ACC ops SHALL use the acc value updated by the preceding op (no stale read).

Reset
REQ-026 rst_n=0 SHALL asynchronously clear stage-1 regs, acc, result, ovf, out_valid; zero SHALL read 1.
REQ-027 Reset mid-pipeline SHALL discard in-flight ops; no out_valid after release until a new in_valid.
REQ-028 First in_valid sampled on the first edge after rst_n rises SHALL be accepted.

Structure
REQ-029 Op codes and default widths SHALL live in package tt_alu_pkg.
REQ-030 One combinational sub-module alu_sat_addsub (add/sub, carry/borrow, saturate) SHALL be instantiated twice or shared; no other hierarchy.

Verification (WIDTH=4, ACC_W=8)
REQ-031 ADD A=9 B=7, sat_en=0 -> 2 cycles later out_valid=1, uo_out=0x10, ovf=0, zero=0.
REQ-032 SUB A=3 B=5: sat_en=0 -> uo_out=0xFE, ovf=1; repeat after CLR with sat_en=1 -> uo_out=0x00, ovf=1, zero=1.
REQ-033 CLR, then 20 back-to-back ACC_ADD A=15 -> out_valid 20 consecutive cycles; final uo_out=0x2C, ovf=1 (sat_en=0); 0xFF with sat_en=1.
REQ-034 ACC_ADD A=5, then ACC_SUB A=5 on next cycle -> uo_out 0x05 then 0x00, zero=1, ovf=0.
REQ-035 Issue 2 ops, pulse rst_n low between them for one cycle -> all outputs 0 (zero=1), no out_valid until new input.
REQ-036 Interleave in_valid=0 and NOP -> result/acc unchanged; out_valid only for the NOP.
